vc_rr_arb_ctrl: RTL and testbench
=================================

VC_RR_ARB_CTRL -- requirements
Module: vc_rr_arb_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter W_IDX, default 2, giving the grant index width (ceil(log2(NUM_REQ))).
REQ-003 The block SHALL have parameter MAX_HOLD, default 16, giving the maximum grant hold in cycles (used only with VC_RR_ARB_TIMEOUT_EN).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester request level.
REQ-007 The block SHALL have port done, input, 1 bit: the current owner signals transaction complete.
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, registered.
REQ-009 The block SHALL have port gnt_idx, output, W_IDX bits: binary index of the owner, registered.
REQ-010 The block SHALL have port gnt_vld, output, 1 bit: a grant is active.
REQ-011 The block SHALL have port timeout, output, 1 bit: a one-cycle pulse on forced release.

Function
REQ-012 The block SHALL have states IDLE (gnt_vld=0) and BUSY (gnt_vld=1).
REQ-013 gnt SHALL equal the one-hot decode of gnt_idx when gnt_vld=1, and all zeros otherwise; at most one bit is ever set.
REQ-014 Arbitration SHALL select the first asserted req bit searching circularly from pointer ptr upward, wrapping from NUM_REQ-1 to 0.
REQ-015 In IDLE with any req bit set, the winner SHALL be registered into gnt_idx and the state SHALL go to BUSY on the next edge (1-cycle req-to-gnt latency).
REQ-016 In IDLE with req all zero, the state and outputs SHALL hold.
REQ-017 In BUSY, the grant SHALL hold while req[gnt_idx]=1 and done=0; requests from other requesters SHALL NOT preempt it.
REQ-018 In BUSY, release SHALL occur when done=1 or req[gnt_idx]=0 (simultaneous done and req drop counts as one release).
REQ-019 On release, ptr SHALL become (gnt_idx+1) mod NUM_REQ, and arbitration SHALL run in the same cycle on the current req using that new ptr.
REQ-020 On release with a winner, the next grant SHALL appear on the next edge with no bubble; with no winner, the state SHALL go to IDLE.
REQ-021 An owner holding req=1 across done SHALL regain the grant only if no other requester is pending (fairness).
REQ-022 Request bits at or above NUM_REQ SHALL NOT exist, and the ptr wrap SHALL use mod NUM_REQ, including when NUM_REQ is not a power of two.

Reset
REQ-023 reset_n=0 SHALL immediately, without a clock, force gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, ptr=0, state=IDLE, and hold count=0.
REQ-024 Reset asserted mid-grant SHALL drop the grant without a done handshake.
REQ-025 After reset deasserts, the first arbitration SHALL start from ptr=0.

Configuration
REQ-026 With macro VC_RR_ARB_TIMEOUT_EN defined, a hold counter SHALL clear on each new grant and increment every BUSY cycle.
REQ-027 With VC_RR_ARB_TIMEOUT_EN defined, when the counter reaches MAX_HOLD-1 with no other release condition, the grant SHALL be force-released per REQ-019/020 and timeout SHALL pulse high for that one cycle.
REQ-028 With VC_RR_ARB_TIMEOUT_EN defined, a timeout coinciding with done SHALL count as a normal release with timeout=0.
REQ-029 Without VC_RR_ARB_TIMEOUT_EN, the counter logic SHALL be absent, timeout SHALL be tied to 0, and a grant SHALL be held indefinitely.

Verification
REQ-030 The bench SHALL cover: reset, then req=4'b0100 at cycle 0 -> gnt=4'b0100, gnt_idx=2, gnt_vld=1 at cycle 1.
REQ-031 The bench SHALL cover: req=4'b1111 with done pulsed every 2 cycles from reset -> grant order 0,1,2,3,0 with no idle cycles between grants.
REQ-032 The bench SHALL cover: owner 1 granted, req[3] rises, owner holds -> gnt stays 4'b0010 until done, then becomes 4'b1000 on the next edge.
REQ-033 The bench SHALL cover: NUM_REQ=3, owner 2 releases with req=3'b101 -> next gnt_idx=0 (wrap).
REQ-034 The bench SHALL cover: reset_n pulled low mid-cycle during a grant -> gnt=0 and gnt_vld=0 before the next clock edge.
REQ-035 The bench SHALL cover, with VC_RR_ARB_TIMEOUT_EN and MAX_HOLD=4: req=4'b0011, done never asserted -> owner 0 for 4 cycles, timeout pulses once, then gnt=4'b0010.

Source files
------------

// File: rtl/vc_rr_arb_ctrl.sv
// vc_rr_arb_ctrl: round-robin arbiter whose grants are held until done or the request drops.
// Define VC_RR_ARB_TIMEOUT_EN to force release of a grant held for MAX_HOLD cycles.
module vc_rr_arb_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int W_IDX    = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [W_IDX-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam int KW = W_IDX + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [W_IDX-1:0]   ptr;
    logic [W_IDX-1:0]   ptr_nxt;
    logic [W_IDX-1:0]   idx_nxt;
    logic [W_IDX-1:0]   rel_ptr;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [KW-1:0]      pick_idle;
    logic [KW-1:0]      pick_rel;
    logic               owner_req;
    logic               force_rel;
    logic               release_any;
    logic               new_grant;

    // Returns {found, index} of the first set bit at or circularly above start.
    function automatic logic [KW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [W_IDX-1:0]   start);
        logic [KW-1:0] res;
        logic [KW-1:0] k;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = {1'b0, start} + KW'(i);
            if (k >= KW'(NUM_REQ)) k = k - KW'(NUM_REQ);
            if (r[k[W_IDX-1:0]]) res = {1'b1, k[W_IDX-1:0]};
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [W_IDX-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign owner_req   = req[gnt_idx];
    assign rel_ptr     = (gnt_idx == W_IDX'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign pick_idle   = rr_pick(req, ptr);
    assign pick_rel    = rr_pick(req, rel_ptr);
    assign release_any = (state == BUSY) && (done || !owner_req || force_rel);
    assign gnt_vld     = (state == BUSY);

    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        ptr_nxt   = ptr;
        new_grant = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[W_IDX]) begin
                    state_nxt = BUSY;
                    idx_nxt   = pick_idle[W_IDX-1:0];
                    new_grant = 1'b1;
                end
            end
            BUSY: begin
                if (release_any) begin
                    // The releasing owner is searched last, so it only regains the grant alone.
                    ptr_nxt = rel_ptr;
                    if (pick_rel[W_IDX]) begin
                        idx_nxt   = pick_rel[W_IDX-1:0];
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = (state_nxt == BUSY) ? onehot(idx_nxt) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gnt_idx <= '0;
            ptr     <= '0;
            gnt     <= '0;
        end else begin
            state   <= state_nxt;
            gnt_idx <= idx_nxt;
            ptr     <= ptr_nxt;
            gnt     <= gnt_nxt;
        end
    end

`ifdef VC_RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;

    logic [CW-1:0] hold_cnt;

    assign force_rel = (state == BUSY) && (hold_cnt == CW'(MAX_HOLD - 1));
    // A timeout that coincides with a normal release is reported as a normal release.
    assign timeout   = force_rel && !done && owner_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (new_grant) begin
            hold_cnt <= '0;
        end else if (state == BUSY) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_vc_rr_arb_ctrl.sv
// Directed testbench for vc_rr_arb_ctrl: a 4-requester instance and a 3-requester wrap instance.
// Timeout scenarios are exercised when VC_RR_ARB_TIMEOUT_EN is defined.
module tb_vc_rr_arb_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    logic [2:0] req3;
    logic       done3;
    logic [2:0] gnt3;
    logic [1:0] gnt_idx3;
    logic       gnt_vld3;
    logic       timeout3;

    int checks = 0;
    int errors = 0;

    vc_rr_arb_ctrl #(.NUM_REQ(4), .W_IDX(2), .MAX_HOLD(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    vc_rr_arb_ctrl #(.NUM_REQ(3), .W_IDX(2), .MAX_HOLD(4)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req3),
        .done    (done3),
        .gnt     (gnt3),
        .gnt_idx (gnt_idx3),
        .gnt_vld (gnt_vld3),
        .timeout (timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required summary before %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        req3    = '0;
        done3   = 1'b0;
        #2;
        reset_n = 1'b1;
        #2;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        req3    = '0;
        done3   = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_vld, timeout} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b idx=%0d vld=%b to=%b, required all zero",
                     gnt, gnt_idx, gnt_vld, timeout);
        end
        checks++;
        if ({gnt3, gnt_idx3, gnt_vld3, timeout3} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs3: got gnt=%b idx=%0d vld=%b to=%b, required all zero",
                     gnt3, gnt_idx3, gnt_vld3, timeout3);
        end
        #1;
        reset_n = 1'b1;
        #2;
    endtask

    task automatic test_single;
        do_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b idx=%0d vld=%b, required 0100 2 1",
                     gnt, gnt_idx, gnt_vld);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got gnt=%b vld=%b, required 0000 0", gnt, gnt_vld);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got gnt=%b vld=%b to=%b, required 0000 0 0",
                     gnt, gnt_vld, timeout);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_i;
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_i = 2'(k % 4);
            exp_g = 4'b0001 << exp_i;
            for (int c = 0; c < 2; c++) begin
                checks++;
                if (gnt !== exp_g || gnt_idx !== exp_i || gnt_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_order k=%0d c=%0d: got gnt=%b idx=%0d vld=%b, required %b %0d 1",
                             k, c, gnt, gnt_idx, gnt_vld, exp_g, exp_i);
                end
                if (c == 0) begin
                    tick();
                end
            end
            done = 1'b1;
            tick();
            done = 1'b0;
        end
    endtask

    task automatic test_no_preempt;
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
                errors++;
                $display("FAIL no_preempt c=%0d: got gnt=%b idx=%0d, required 0010 1", c, gnt, gnt_idx);
            end
            tick();
        end
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL no_preempt_final: got gnt=%b, required 0010", gnt);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL handover: got gnt=%b idx=%0d vld=%b, required 1000 3 1", gnt, gnt_idx, gnt_vld);
        end
    endtask

    task automatic test_fairness;
        do_reset();
        req = 4'b0011;
        tick();
        done = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            errors++;
            $display("FAIL fair_pass: got gnt=%b idx=%0d, required 0010 1", gnt, gnt_idx);
        end
        req = 4'b0010;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0010 || gnt_vld !== 1'b1) begin
            errors++;
            $display("FAIL fair_regain: got gnt=%b vld=%b, required 0010 1", gnt, gnt_vld);
        end
    endtask

    task automatic test_wrap3;
        do_reset();
        req3 = 3'b100;
        tick();
        checks++;
        if (gnt3 !== 3'b100 || gnt_idx3 !== 2'd2) begin
            errors++;
            $display("FAIL wrap_first: got gnt=%b idx=%0d, required 100 2", gnt3, gnt_idx3);
        end
        req3 = 3'b101;
        tick();
        checks++;
        if (gnt3 !== 3'b100) begin
            errors++;
            $display("FAIL wrap_hold: got gnt=%b, required 100", gnt3);
        end
        done3 = 1'b1;
        tick();
        done3 = 1'b0;
        checks++;
        if (gnt3 !== 3'b001 || gnt_idx3 !== 2'd0 || gnt_vld3 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_next: got gnt=%b idx=%0d vld=%b, required 001 0 1", gnt3, gnt_idx3, gnt_vld3);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req = 4'b0011;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got gnt=%b idx=%0d vld=%b, required 0000 0 0", gnt, gnt_idx, gnt_vld);
        end
        reset_n = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr: got gnt=%b idx=%0d, required 0001 0", gnt, gnt_idx);
        end
    endtask

`ifdef VC_RR_ARB_TIMEOUT_EN
    task automatic test_timeout;
        logic exp_t;
        int   pulses;
        pulses = 0;
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 4; c++) begin
            tick();
            exp_t = (c == 3);
            if (timeout === 1'b1) pulses++;
            checks++;
            if (gnt !== 4'b0001 || timeout !== exp_t) begin
                errors++;
                $display("FAIL timeout_hold c=%0d: got gnt=%b to=%b, required 0001 %b", c, gnt, timeout, exp_t);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || timeout !== 1'b0 || pulses !== 1) begin
            errors++;
            $display("FAIL timeout_release: got gnt=%b to=%b pulses=%0d, required 0010 0 1", gnt, timeout, pulses);
        end
        tick();
        tick();
        tick();
        checks++;
        if (timeout !== 1'b1 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_second: got gnt=%b to=%b, required 0010 1", gnt, timeout);
        end
        done = 1'b1;
        #1;
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_with_done: got to=%b, required 0", timeout);
        end
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_done_next: got gnt=%b to=%b, required 0001 0", gnt, timeout);
        end
    endtask
`else
    task automatic test_hold_forever;
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL hold_forever c=%0d: got gnt=%b to=%b, required 0001 0", c, gnt, timeout);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_fairness();
        test_wrap3();
        test_reset_mid();
`ifdef VC_RR_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
